data_mem_hs: RTL and testbench
==============================

# data_mem_hs

Parametrised, handshaked data memory for the CPU load/store path. It supports byte, halfword and word accesses with per-lane write enables and sign/zero extension on loads. Alignment and range errors are reported instead of silently corrupting memory. A programmable wait-state counter models slow memory, and an optional post-reset clear sweep zeroes the array. It replaces the flat single-cycle data memory behind the MEM stage.

## Interface
Parameters:
- `DEPTH_WORDS`, default 512: number of 32-bit words. Must be a power of two, ≥ 2.
- `WAIT_CYCLES`, default 0: extra cycles between accept and memory access, 0..15.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer takes the response.
- `resp_rdata` out 32: load result, extended. 0 for stores and errors.
- `resp_err` out 1: access rejected.

## Operation
- Storage: DEPTH_WORDS × 32-bit words, little-endian, 4 byte lanes. Word index = `req_addr[AW+1:2]`, where AW = log2(DEPTH_WORDS).
- FSM states: CLEAR, IDLE, WAIT, RESP.
- CLEAR (only with macro):
  - Index counter runs 0..DEPTH_WORDS-1, writing one word of 0 per cycle.
  - Goes to IDLE after the last word is written.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid` && `req_ready`, capture we, size, unsigned, addr and wdata.
  - Go to WAIT if `WAIT_CYCLES` > 0, else perform the access on the same edge and go to RESP.
- WAIT: counter loads `WAIT_CYCLES`-1 and decrements. At the edge where it reaches 0, perform the access and go to RESP.
- RESP:
  - `resp_valid` = 1, with `resp_rdata` and `resp_err` held stable.
  - On `resp_ready`, go to IDLE.
  - No new request is accepted in the same cycle.
- Error (checked at access time), when any of the following holds:
  - size == 11;
  - half with addr[0] = 1;
  - word with addr[1:0] ≠ 0;
  - addr ≥ 4·DEPTH_WORDS (any of addr[31:AW+2] set).
- On error: no memory change, `resp_err` = 1, `resp_rdata` = 0.
- Store lane enables:
  - byte: lane addr[1:0];
  - half: lanes {addr[1],0} and {addr[1],1};
  - word: all lanes.
- Store data is replicated to the selected lanes from `req_wdata` low bits.
- Load:
  - Select the byte or half from the word by addr[1:0].
  - Extend to 32 bits: sign from bit 7 or bit 15 unless `req_unsigned`.
  - Word loads ignore `req_unsigned`.
- Only one outstanding request at a time. No read-during-write hazard is possible.

## Timing
- Reset values (asynchronous):
  - `req_ready` = 0 with macro (CLEAR) or 1 without (IDLE).
  - `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0.
  - Wait and index counters = 0.
- Latency: request accepted in cycle N → `resp_valid` high in cycle N+1+`WAIT_CYCLES`.
  - Held until the `resp_ready` cycle inclusive.
  - Throughput at best is one request per 2+`WAIT_CYCLES` cycles.
- A store is committed on the access edge. A load observing the same word in a later transaction sees the new value.
- Reset mid-transaction:
  - FSM is forced to CLEAR or IDLE.
  - A store not yet at its access edge is dropped.
  - A pending response is discarded.
- Reset during CLEAR restarts the sweep at index 0.
- `req_valid` while not in IDLE: ignored. The requester must hold the request until `req_ready`.

## Configuration
- `DATA_MEM_CLEAR_EN` defined:
  - After reset, CLEAR runs for DEPTH_WORDS cycles with `req_ready` = 0.
  - All words read 0 afterwards.
- `DATA_MEM_CLEAR_EN` undefined:
  - No CLEAR state; reset enters IDLE directly.
  - The memory array is not reset, and contents survive `rst_n`.
  - The array is preloadable by bench.

## Test plan
- Clear sweep (macro on, DEPTH_WORDS=16): release reset → `req_ready` low for exactly 16 cycles, then word load of 0x3C returns 0x00000000 with `resp_err`=0.
- Sized store/load: word store 0x11223344 @0x10; byte store 0xAA @0x12; then:
  - word load @0x10 → 0x11AA3344;
  - signed byte load @0x12 → 0xFFFFFFAA;
  - unsigned half load @0x12 → 0x000011AA.
- Misalignment: word store @0x11 and half load @0x13 → `resp_err`=1, `resp_rdata`=0. Word @0x10 unchanged afterwards.
- Range: DEPTH_WORDS=16, load @0x40 and store @0x80000000 → `resp_err`=1, no memory change; size=11 → `resp_err`=1.
- Wait states and backpressure: `WAIT_CYCLES`=3, accept in cycle N → `resp_valid` rises in cycle N+4. Hold `resp_ready`=0 for 5 cycles → rdata/err stable and `req_ready`=0 throughout.
- Reset mid-operation: `WAIT_CYCLES`=3, store 0xDEADBEEF @0x20, assert `rst_n`=0 one cycle after accept (macro off) → `resp_valid` drops immediately and a later load @0x20 returns the prior value.

Source files
------------

// File: rtl/data_mem_hs.sv
// Handshaked byte/half/word data memory with alignment/range checks and wait states.
// Optional post-reset zero sweep of the array is enabled by defining DATA_MEM_CLEAR_EN.
module data_mem_hs #(
  parameter int DEPTH_WORDS = 512,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      wait_cnt_reg, wait_cnt_next;
  logic [AW-1:0]   clr_idx_reg, clr_idx_next;
  logic            we_reg, we_next;
  logic [1:0]      size_reg, size_next;
  logic            uns_reg, uns_next;
  logic [31:0]     addr_reg, addr_next;
  logic [31:0]     wdata_reg, wdata_next;
  logic [31:0]     rdata_reg, rdata_next;
  logic            err_reg, err_next;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            acc_we, acc_uns, acc_err, do_access;
  logic [1:0]      acc_size;
  logic [31:0]     acc_addr, acc_wdata;
  logic [AW-1:0]   acc_idx;
  logic [31:0]     rd_word, wdata_rep, merged_word, load_val, byte_sel;
  logic [15:0]     half_sel;
  logic [3:0]      lane_be;
  logic            mem_we;
  logic [AW-1:0]   mem_widx;
  logic [31:0]     mem_wdata;

  // With zero wait states the access happens on the accept edge, so it uses the live request.
  always_comb begin
    if (state_reg == ST_IDLE) begin
      acc_we    = req_we;
      acc_size  = req_size;
      acc_uns   = req_unsigned;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = we_reg;
      acc_size  = size_reg;
      acc_uns   = uns_reg;
      acc_addr  = addr_reg;
      acc_wdata = wdata_reg;
    end
  end

  assign acc_idx = acc_addr[AW+1:2];
  assign rd_word = mem[acc_idx];

  always_comb begin
    acc_err = 1'b0;
    if (acc_size == 2'b11) acc_err = 1'b1;
    if (acc_size == 2'b01 && acc_addr[0]) acc_err = 1'b1;
    if (acc_size == 2'b10 && acc_addr[1:0] != 2'b00) acc_err = 1'b1;
    if ((acc_addr >> (AW + 2)) != 32'd0) acc_err = 1'b1;
  end

  always_comb begin
    lane_be   = 4'b1111;
    wdata_rep = acc_wdata;
    case (acc_size)
      2'b00: begin
        lane_be   = 4'b0001 << acc_addr[1:0];
        wdata_rep = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        lane_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{acc_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[gi*8 +: 8] = lane_be[gi] ? wdata_rep[gi*8 +: 8] : rd_word[gi*8 +: 8];
    end
  endgenerate

  assign byte_sel = rd_word >> {acc_addr[1:0], 3'b000};
  assign half_sel = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (acc_size)
      2'b00:   load_val = acc_uns ? {24'd0, byte_sel[7:0]} : {{24{byte_sel[7]}}, byte_sel[7:0]};
      2'b01:   load_val = acc_uns ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_val = rd_word;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    clr_idx_next  = clr_idx_reg;
    we_next       = we_reg;
    size_next     = size_reg;
    uns_next      = uns_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    rdata_next    = rdata_reg;
    err_next      = err_reg;
    do_access     = 1'b0;
    mem_we        = 1'b0;
    mem_widx      = acc_idx;
    mem_wdata     = merged_word;
    case (state_reg)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_widx  = clr_idx_reg;
        mem_wdata = 32'd0;
        if (clr_idx_reg == AW'(DEPTH_WORDS - 1)) state_next = ST_IDLE;
        else clr_idx_next = clr_idx_reg + 1'b1;
      end
      ST_IDLE: begin
        if (req_valid) begin
          we_next    = req_we;
          size_next  = req_size;
          uns_next   = req_unsigned;
          addr_next  = req_addr;
          wdata_next = req_wdata;
          if (WAIT_CYCLES > 0) begin
            wait_cnt_next = 4'(WAIT_CYCLES - 1);
            state_next    = ST_WAIT;
          end else begin
            do_access  = 1'b1;
            state_next = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_reg == 4'd0) begin
          do_access  = 1'b1;
          state_next = ST_RESP;
        end else begin
          wait_cnt_next = wait_cnt_reg - 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          rdata_next = 32'd0;
          err_next   = 1'b0;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (do_access) begin
      err_next   = acc_err;
      rdata_next = (acc_err || acc_we) ? 32'd0 : load_val;
      mem_we     = acc_we && !acc_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef DATA_MEM_CLEAR_EN
      state_reg <= ST_CLEAR;
`else
      state_reg <= ST_IDLE;
`endif
      wait_cnt_reg <= '0;
      clr_idx_reg  <= '0;
      we_reg       <= 1'b0;
      size_reg     <= 2'b00;
      uns_reg      <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      clr_idx_reg  <= clr_idx_next;
      we_reg       <= we_next;
      size_reg     <= size_next;
      uns_reg      <= uns_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      rdata_reg    <= rdata_next;
      err_reg      <= err_next;
    end
  end

  // Array has no reset; gating with rst_n keeps a store from landing while reset is held.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) mem[mem_widx] <= mem_wdata;
  end

  assign req_ready  = (state_reg == ST_IDLE);
  assign resp_valid = (state_reg == ST_RESP);
  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg;

endmodule

// File: tb/tb_data_mem_hs.sv
// Directed bench for data_mem_hs (DEPTH_WORDS=16, WAIT_CYCLES=3); honours DATA_MEM_CLEAR_EN.
module tb_data_mem_hs;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

`ifdef DATA_MEM_CLEAR_EN
  localparam logic RST_READY = 1'b0;
  localparam logic [31:0] PRIOR_20 = 32'h0000_0000;
`else
  localparam logic RST_READY = 1'b1;
  localparam logic [31:0] PRIOR_20 = 32'hCAFE_F00D;
`endif
  localparam int LAT = 4;

  always #5 clk = ~clk;

  data_mem_hs #(.DEPTH_WORDS(16), .WAIT_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic e, output int lat);
    @(negedge clk);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 50);
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL resp_timeout: resp_valid=%b required 1", resp_valid);
    end
    rd = resp_rdata; e = resp_err;
    $display("xact we=%0b size=%0d uns=%0b addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
             we, sz, uns, a, wd, rd, e, lat);
    resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== RST_READY) begin errors++; $display("FAIL rst_req_ready: got %b required %b", req_ready, RST_READY); end
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b required 0", resp_valid); end
    checks++;
    if (resp_rdata !== 32'd0) begin errors++; $display("FAIL rst_resp_rdata: got %h required 0", resp_rdata); end
    checks++;
    if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err: got %b required 0", resp_err); end
    rst_n = 1'b1;
  endtask

`ifdef DATA_MEM_CLEAR_EN
  task automatic test_clear();
    int cnt = 0;
    logic [31:0] rd; logic e; int lat;
    while (!req_ready && cnt < 100) begin cnt++; @(negedge clk); end
    checks++;
    if (cnt != 16) begin errors++; $display("FAIL clear_cycles: got %0d required 16", cnt); end
    xact(1'b0, 2'b10, 1'b0, 32'h3C, 32'd0, rd, e, lat);
    chk("clear_load_3c", rd, 32'd0);
    chk("clear_load_err", {31'd0, e}, 32'd0);
  endtask
`endif

  task automatic test_sized();
    logic [31:0] rd; logic e; int lat;
    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, rd, e, lat);
    chk("st_word_err", {31'd0, e}, 32'd0);
    chk("st_word_rdata", rd, 32'd0);
    chk("st_word_lat", 32'(lat), 32'(LAT));
    xact(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AA, rd, e, lat);
    chk("st_byte_err", {31'd0, e}, 32'd0);
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, e, lat);
    chk("ld_word_10", rd, 32'h11AA_3344);
    xact(1'b0, 2'b00, 1'b0, 32'h12, 32'd0, rd, e, lat);
    chk("ld_sbyte_12", rd, 32'hFFFF_FFAA);
    xact(1'b0, 2'b01, 1'b1, 32'h12, 32'd0, rd, e, lat);
    chk("ld_uhalf_12", rd, 32'h0000_11AA);
    xact(1'b0, 2'b00, 1'b1, 32'h10, 32'd0, rd, e, lat);
    chk("ld_ubyte_10", rd, 32'h0000_0044);
    xact(1'b1, 2'b01, 1'b0, 32'h16, 32'h1234_BEEF, rd, e, lat);
    xact(1'b0, 2'b01, 1'b0, 32'h16, 32'd0, rd, e, lat);
    chk("ld_shalf_16", rd, 32'hFFFF_BEEF);
    xact(1'b0, 2'b10, 1'b1, 32'h10, 32'd0, rd, e, lat);
    chk("ld_word_uns_ignored", rd, 32'h11AA_3344);
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic e; int lat;
    xact(1'b1, 2'b10, 1'b0, 32'h11, 32'hFFFF_FFFF, rd, e, lat);
    chk("mis_word_err", {31'd0, e}, 32'd1);
    chk("mis_word_rdata", rd, 32'd0);
    xact(1'b0, 2'b01, 1'b0, 32'h13, 32'd0, rd, e, lat);
    chk("mis_half_err", {31'd0, e}, 32'd1);
    chk("mis_half_rdata", rd, 32'd0);
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, e, lat);
    chk("mis_word_unchanged", rd, 32'h11AA_3344);
    chk("mis_after_err", {31'd0, e}, 32'd0);
  endtask

  task automatic test_range();
    logic [31:0] rd; logic e; int lat;
    xact(1'b1, 2'b10, 1'b0, 32'h0, 32'h5566_7788, rd, e, lat);
    xact(1'b0, 2'b10, 1'b0, 32'h40, 32'd0, rd, e, lat);
    chk("rng_ld40_err", {31'd0, e}, 32'd1);
    chk("rng_ld40_rdata", rd, 32'd0);
    xact(1'b1, 2'b10, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, rd, e, lat);
    chk("rng_st_hi_err", {31'd0, e}, 32'd1);
    xact(1'b1, 2'b11, 1'b0, 32'h0, 32'h0BAD_0BAD, rd, e, lat);
    chk("size11_err", {31'd0, e}, 32'd1);
    xact(1'b0, 2'b10, 1'b0, 32'h0, 32'd0, rd, e, lat);
    chk("rng_word0_unchanged", rd, 32'h5566_7788);
  endtask

  task automatic test_backpressure();
    int lat = 0;
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1 req_valid = 1'b0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 50);
    chk("bp_latency", 32'(lat), 32'(LAT));
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_held", {31'd0, resp_valid}, 32'd1);
      chk("bp_rdata_stable", resp_rdata, 32'h11AA_3344);
      chk("bp_err_stable", {31'd0, resp_err}, 32'd0);
      chk("bp_req_ready_low", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    $display("xact backpressure load addr=00000010 rdata=%h held 5 cycles", resp_rdata);
    resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    @(negedge clk);
    chk("bp_released", {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic e; int lat;
    int n = 0;
    xact(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D, rd, e, lat);
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst_req_ready", {31'd0, req_ready}, {31'd0, RST_READY});
    @(negedge clk); rst_n = 1'b1;
    $display("xact store addr=00000020 wdata=deadbeef interrupted by reset");
    xact(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, rd, e, lat);
    chk("midrst_store_dropped", rd, PRIOR_20);
    // Reset while a response is pending: it must vanish asynchronously.
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_addr = 32'h20; req_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1 req_valid = 1'b0;
    while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    chk("resp_before_rst", {31'd0, resp_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_discard_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_discard_rdata", resp_rdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    xact(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, rd, e, lat);
    chk("post_rst_lat", 32'(lat), 32'(LAT));
    chk("post_rst_load", rd, PRIOR_20);
  endtask

  initial begin
    test_reset();
`ifdef DATA_MEM_CLEAR_EN
    test_clear();
`endif
    test_sized();
    test_misalign();
    test_range();
    test_backpressure();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
